// File: rtl/lvds_cda_align_sm.sv
// ---------------------------------------------------------------------------
// lvds_cda_align_sm
//
// Channel-data-align controller for the LVDS receive/demux stage. After a
// start request it pulses the per-lane align reset, waits for PLL lock, then
// walks the lanes in order (lane 0 first). For each lane it compares the
// deserialiser word against the training pattern and issues single-clock
// bit-slip pulses until the pattern holds for MATCH_COUNT consecutive words.
// A lane that needs MAX_SLIPS slips is flagged in lane_err and skipped.
// When all lanes have been visited, cda_rdy is raised if no lane failed.
//
// Ports
//   clk           rx_outclock domain clock
//   rst_n         synchronous active-low reset
//   start         one-cycle (re)train request, honoured only in IDLE / DONE
//   rx_locked     LVDS PLL lock
//   rx_out        deserialiser words, lane n = rx_out[n*DESER +: DESER]
//   rx_cda_reset  per-lane align reset (all lanes together)
//   rx_cda        per-lane slip pulse, one-hot, one clock wide
//   cda_rdy       all lanes aligned
//   busy          training in progress
//   lane_err      sticky per-lane failure flags, cleared by start
//
// Build option
//   CDA_AUTO_RETRAIN_EN  when defined, lock loss in DONE restarts training
//                        on its own; otherwise the block returns to IDLE and
//                        waits for start.
//
// All outputs are registered from the next-state decode, so they line up
// with the state register and are clean zeros out of reset.
// ---------------------------------------------------------------------------
module lvds_cda_align_sm #(
    parameter int              NUM_LANES     = 9,
    parameter int              DESER         = 10,
    parameter logic [DESER-1:0] TRAIN_PATTERN = 10'h3E0,
    parameter int              RST_CYCLES    = 4,
    parameter int              SETTLE_CYCLES = 8,
    parameter int              MATCH_COUNT   = 16,
    parameter int              MAX_SLIPS     = 20
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       rx_locked,
    input  logic [NUM_LANES*DESER-1:0] rx_out,
    output logic [NUM_LANES-1:0]       rx_cda_reset,
    output logic [NUM_LANES-1:0]       rx_cda,
    output logic                       cda_rdy,
    output logic                       busy,
    output logic [NUM_LANES-1:0]       lane_err
);

    localparam int LANE_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int RST_W   = $clog2(RST_CYCLES + 1);
    localparam int SET_W   = $clog2(SETTLE_CYCLES + 1);
    localparam int MATCH_W = $clog2(MATCH_COUNT + 1);
    localparam int SLIP_W  = $clog2(MAX_SLIPS + 1);

    localparam logic [LANE_W-1:0]  LANE_LAST  = LANE_W'(NUM_LANES - 1);
    localparam logic [RST_W-1:0]   RST_LAST   = RST_W'(RST_CYCLES - 1);
    localparam logic [SET_W-1:0]   SET_LAST   = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(MATCH_COUNT - 1);
    localparam logic [SLIP_W-1:0]  SLIP_MAX   = SLIP_W'(MAX_SLIPS);

    typedef enum logic [2:0] {
        IDLE,
        CDA_RST,
        WAIT_LOCK,
        SETTLE,
        CHECK,
        SLIP,
        NEXT,
        DONE
    } state_t;

    state_t               state_q,     state_d;
    logic [LANE_W-1:0]    lane_q,      lane_d;
    logic [SLIP_W-1:0]    slip_q,      slip_d;
    logic [RST_W-1:0]     rst_cnt_q,   rst_cnt_d;
    logic [SET_W-1:0]     set_cnt_q,   set_cnt_d;
    logic [MATCH_W-1:0]   match_q,     match_d;
    logic [NUM_LANES-1:0] lane_err_q,  lane_err_d;
    logic [NUM_LANES-1:0] cda_rst_q,   cda_rst_d;
    logic [NUM_LANES-1:0] cda_q,       cda_d;
    logic                 rdy_q,       rdy_d;
    logic                 busy_q,      busy_d;

    logic [DESER-1:0]     lane_word [NUM_LANES];
    logic [DESER-1:0]     cur_word;
    logic                 go_rst;
    logic [SLIP_W-1:0]    slip_inc;

    // Word of the lane currently being trained.
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_word[i] = rx_out[i*DESER +: DESER];
        end
        cur_word = lane_word[lane_q];
    end

    // Saturating slip increment so the counter can never wrap.
    assign slip_inc = (slip_q == SLIP_MAX) ? slip_q : slip_q + SLIP_W'(1);

    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        slip_d     = slip_q;
        rst_cnt_d  = rst_cnt_q;
        set_cnt_d  = set_cnt_q;
        match_d    = match_q;
        lane_err_d = lane_err_q;
        go_rst     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) go_rst = 1'b1;
            end

            CDA_RST: begin
                if (rst_cnt_q == RST_LAST) state_d = WAIT_LOCK;
                else                       rst_cnt_d = rst_cnt_q + RST_W'(1);
            end

            WAIT_LOCK: begin
                if (rx_locked) state_d = SETTLE;
            end

            SETTLE: begin
                if (!rx_locked)                state_d = WAIT_LOCK;
                else if (set_cnt_q == SET_LAST) state_d = CHECK;
                else                           set_cnt_d = set_cnt_q + SET_W'(1);
            end

            CHECK: begin
                if (!rx_locked) begin
                    state_d = WAIT_LOCK;
                end else if (cur_word != TRAIN_PATTERN) begin
                    // A lane can only be back here at the slip limit if lock
                    // dropped on its final slip; it is already flagged.
                    state_d = (slip_q == SLIP_MAX) ? NEXT : SLIP;
                end else if (match_q == MATCH_LAST) begin
                    state_d = NEXT;
                end else begin
                    match_d = match_q + MATCH_W'(1);
                end
            end

            SLIP: begin
                // The pulse is on the pins this cycle, so it counts even if
                // lock is lost at the same time.
                slip_d = slip_inc;
                if (slip_inc == SLIP_MAX) lane_err_d[lane_q] = 1'b1;
                if (!rx_locked)                state_d = WAIT_LOCK;
                else if (slip_inc == SLIP_MAX) state_d = NEXT;
                else                           state_d = SETTLE;
            end

            NEXT: begin
                // Lane advance is held back on lock loss so the relock
                // resumes the same lane cleanly.
                if (!rx_locked) begin
                    state_d = WAIT_LOCK;
                end else begin
                    slip_d = '0;
                    if (lane_q == LANE_LAST) begin
                        state_d = DONE;
                    end else begin
                        lane_d  = lane_q + LANE_W'(1);
                        state_d = SETTLE;
                    end
                end
            end

            DONE: begin
                if (start) begin
                    go_rst = 1'b1;
                end else if (!rx_locked) begin
`ifdef CDA_AUTO_RETRAIN_EN
                    go_rst = 1'b1;
`else
                    state_d = IDLE;
`endif
                end
            end

            default: state_d = IDLE;
        endcase

        if (go_rst) begin
            state_d    = CDA_RST;
            rst_cnt_d  = '0;
            lane_d     = '0;
            slip_d     = '0;
            lane_err_d = '0;
        end

        // Timers restart on every entry into their state.
        if (state_d == SETTLE && state_q != SETTLE) set_cnt_d = '0;
        if (state_d == CHECK  && state_q != CHECK)  match_d   = '0;
    end

    // Output decode from the next state; registered below.
    always_comb begin
        cda_rst_d = (state_d == CDA_RST) ? {NUM_LANES{1'b1}} : '0;
        cda_d     = '0;
        if (state_d == SLIP) cda_d[lane_d] = 1'b1;
        rdy_d     = (state_d == DONE) && (lane_err_d == '0);
        busy_d    = !(state_d inside {IDLE, DONE});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lane_q     <= '0;
            slip_q     <= '0;
            rst_cnt_q  <= '0;
            set_cnt_q  <= '0;
            match_q    <= '0;
            lane_err_q <= '0;
            cda_rst_q  <= '0;
            cda_q      <= '0;
            rdy_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            slip_q     <= slip_d;
            rst_cnt_q  <= rst_cnt_d;
            set_cnt_q  <= set_cnt_d;
            match_q    <= match_d;
            lane_err_q <= lane_err_d;
            cda_rst_q  <= cda_rst_d;
            cda_q      <= cda_d;
            rdy_q      <= rdy_d;
            busy_q     <= busy_d;
        end
    end

    assign rx_cda_reset = cda_rst_q;
    assign rx_cda       = cda_q;
    assign cda_rdy      = rdy_q;
    assign busy         = busy_q;
    assign lane_err     = lane_err_q;

endmodule
